// File: rtl/params.sv
// Shared constants and types for the bullet pool: screen geometry, bullet kinematics,
// pool defaults and the sweep FSM encoding.
package params;

  localparam int VRES         = 480;
  localparam int PADDLE_H     = 20;
  localparam int BULLET_H     = 8;
  localparam int BULLET_W     = 4;
  localparam int BULLET_SPEED = 4;

  localparam int N_SLOTS_DEFAULT         = 4;
  localparam int COOLDOWN_FRAMES_DEFAULT = 8;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    ALLOC  = 2'd2
  } pool_state_t;

  // Bullets spawn with their bottom edge resting on top of the paddle.
  function automatic logic [COORD_W-1:0] spawn_y();
    return COORD_W'(VRES - PADDLE_H - BULLET_H);
  endfunction

endpackage

// File: rtl/bullet_pool_ctrl_first_free_enc.sv
// Lowest-index free slot finder: purely combinational priority encoder over the
// active mask; free_vld is low when every slot is in flight.
module first_free_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     slot_active,
  output logic             free_vld,
  output logic [IDX_W-1:0] free_idx
);

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    // Walk downward so the lowest free index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet pool: per-frame sweep moves each in-flight bullet up one step, then one
// allocation slot spawns a bullet on a pending press; fsync->fire_ack is N_SLOTS+1 cycles.
module bullet_pool_ctrl
  import params::*;
#(
  parameter int N_SLOTS         = N_SLOTS_DEFAULT,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  fsync,
  input  logic                  fire,
  input  logic [11:0]           player_x,
  input  logic [N_SLOTS-1:0]    hit,
  output logic [N_SLOTS-1:0]    slot_active,
  output logic [N_SLOTS*12-1:0] slot_x,
  output logic [N_SLOTS*12-1:0] slot_y,
  output logic                  fire_ack,
  output logic                  busy
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic signed [11:0] SPEED     = 12'(BULLET_SPEED);
  localparam logic [11:0]        SPAWN_Y   = spawn_y();
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_SLOTS - 1);
  localparam logic [CD_W-1:0]    CD_RELOAD = CD_W'(COOLDOWN_FRAMES);

  pool_state_t      state;
  pool_state_t      state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;

  logic [2:0]         fire_sync;
  logic               fire_prev;
  logic               press;
  logic               fire_pending;
  logic [CD_W-1:0]    cooldown;
  logic [N_SLOTS-1:0] hit_pend;
  logic [11:0]        pos_x [N_SLOTS];
  logic [11:0]        pos_y [N_SLOTS];

  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             alloc_go;

  assign press = fire_sync[2] & ~fire_prev;

  first_free_enc #(
    .N     (N_SLOTS),
    .IDX_W (IDX_W)
  ) u_first_free (
    .slot_active (slot_active),
    .free_vld    (free_vld),
    .free_idx    (free_idx)
  );

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    alloc_go  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fsync) begin
          state_nxt = UPDATE;
          idx_nxt   = '0;
        end
      end
      UPDATE: begin
        if (idx == LAST_IDX) begin
          state_nxt = ALLOC;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ALLOC: begin
        alloc_go  = fire_pending && (cooldown == '0) && free_vld;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      fire_sync    <= '0;
      fire_prev    <= 1'b0;
      fire_pending <= 1'b0;
      cooldown     <= '0;
      fire_ack     <= 1'b0;
      hit_pend     <= '0;
      slot_active  <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      fire_sync <= {fire_sync[1:0], fire};
      fire_prev <= fire_sync[2];
      fire_ack  <= alloc_go;

      for (int i = 0; i < N_SLOTS; i++) begin
        if (state == UPDATE && idx == IDX_W'(i)) begin
          // A hit landing on the very cycle of processing is folded in here.
          hit_pend[i] <= 1'b0;
          if (slot_active[i]) begin
            if (hit_pend[i] || hit[i]) begin
              slot_active[i] <= 1'b0;
            end else if ($signed(pos_y[i]) > SPEED) begin
              pos_y[i] <= pos_y[i] - SPEED;
            end else begin
              slot_active[i] <= 1'b0;
            end
          end
        end else if (hit[i] && slot_active[i]) begin
          hit_pend[i] <= 1'b1;
        end
      end

      if (alloc_go) begin
        slot_active[free_idx] <= 1'b1;
        pos_x[free_idx]       <= player_x;
        pos_y[free_idx]       <= SPAWN_Y;
      end

      // Presses never carry across frames, but a press in the ALLOC cycle itself survives.
      if (state == ALLOC) begin
        if (alloc_go) begin
          cooldown <= CD_RELOAD;
        end else if (cooldown != '0) begin
          cooldown <= cooldown - CD_W'(1);
        end
        fire_pending <= press;
      end else if (press) begin
        fire_pending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign slot_x[12*g +: 12] = pos_x[g];
    assign slot_y[12*g +: 12] = pos_y[g];
  end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Bench for bullet_pool_ctrl: directed frame scenarios plus randomized traffic, all
// checked every cycle against a frame-level behavioural model of the pool.
module tb_bullet_pool_ctrl;

  localparam int N     = 4;
  localparam int CD    = 8;
  localparam int SPAWN = 480 - 20 - 8;
  localparam int SPD   = 4;

  logic            pixel_clk = 1'b0;
  logic            rst_n     = 1'b0;
  logic            fsync     = 1'b0;
  logic            fire      = 1'b0;
  logic [11:0]     player_x  = '0;
  logic [N-1:0]    hit       = '0;
  logic [N-1:0]    slot_active;
  logic [N*12-1:0] slot_x;
  logic [N*12-1:0] slot_y;
  logic            fire_ack;
  logic            busy;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_en = 1'b0;

  bullet_pool_ctrl #(
    .N_SLOTS         (N),
    .COOLDOWN_FRAMES (CD)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .fsync       (fsync),
    .fire        (fire),
    .player_x    (player_x),
    .hit         (hit),
    .slot_active (slot_active),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .fire_ack    (fire_ack),
    .busy        (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: phase -1 is idle, 0..N-1 is the slot swept next, N is allocation.
  int          phase = -1;
  bit          m_act [N];
  bit [11:0]   m_x [N];
  bit [11:0]   m_y [N];
  bit          m_pend [N];
  bit          old_act [N];
  int          m_cd = 0;
  bit          m_fp = 1'b0;
  bit          m_ack = 1'b0;
  bit          fh [5];
  bit          press_m;
  bit          h;
  int          fr;

  always @(posedge pixel_clk) begin
    if (!rst_n) begin
      phase = -1;
      m_cd  = 0;
      m_fp  = 1'b0;
      m_ack = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; m_pend[i] = 1'b0;
      end
      for (int k = 0; k < 5; k++) fh[k] = 1'b0;
    end else begin
      for (int k = 4; k > 0; k--) fh[k] = fh[k-1];
      fh[0]   = fire;
      press_m = fh[3] && !fh[4];
      m_ack   = 1'b0;
      old_act = m_act;
      for (int i = 0; i < N; i++)
        if (phase != i && hit[i] && old_act[i]) m_pend[i] = 1'b1;
      if (phase < 0) begin
        if (fsync) phase = 0;
      end else if (phase < N) begin
        h = m_pend[phase] || (hit[phase] && old_act[phase]);
        m_pend[phase] = 1'b0;
        if (m_act[phase]) begin
          if (h) m_act[phase] = 1'b0;
          else if ($signed(m_y[phase]) > 12'sd4) m_y[phase] = m_y[phase] - 12'(SPD);
          else m_act[phase] = 1'b0;
        end
        phase++;
      end else begin
        fr = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_act[i]) fr = i;
        if (m_fp && m_cd == 0 && fr >= 0) begin
          m_act[fr] = 1'b1;
          m_x[fr]   = player_x;
          m_y[fr]   = 12'(SPAWN);
          m_ack     = 1'b1;
          m_cd      = CD;
        end else if (m_cd > 0) begin
          m_cd--;
        end
        m_fp  = 1'b0;
        phase = -1;
      end
      if (press_m) m_fp = 1'b1;
    end
  end

  logic [N-1:0]    e_act;
  logic [N*12-1:0] e_x;
  logic [N*12-1:0] e_y;

  always @(negedge pixel_clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_act[i]       = m_act[i];
        e_x[12*i +: 12] = m_x[i];
        e_y[12*i +: 12] = m_y[i];
      end
      cmp("model_slot_active", 64'(slot_active), 64'(e_act));
      cmp("model_slot_x", 64'(slot_x), 64'(e_x));
      cmp("model_slot_y", 64'(slot_y), 64'(e_y));
      cmp("model_fire_ack", 64'(fire_ack), 64'(m_ack));
      cmp("model_busy", 64'(busy), 64'(phase >= 0));
    end
  end

  task automatic cyc();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic frame(input bit pr, output bit acked);
    acked = 1'b0;
    if (pr) begin
      fire = 1'b1; cyc(); cyc();
      fire = 1'b0; repeat (4) cyc();
    end else begin
      repeat (2) cyc();
    end
    fsync = 1'b1; cyc(); fsync = 1'b0;
    repeat (7) begin
      cyc();
      if (fire_ack) acked = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    bit seen4;
    int lat;
    int n;
    int ack_frames [$];

    rst_n = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    cmp("reset_busy", 64'(busy), 64'd0);
    cmp("reset_active", 64'(slot_active), 64'd0);
    cmp("reset_ack", 64'(fire_ack), 64'd0);
    rst_n = 1'b1;
    cyc();

    // First shot: ack exactly five cycles after fsync, slot 0 at the spawn point.
    player_x = 12'd320;
    fire = 1'b1; cyc(); cyc(); fire = 1'b0; repeat (4) cyc();
    fsync = 1'b1; cyc(); fsync = 1'b0;
    lat = 0;
    while (!fire_ack && lat < 20) begin
      cyc();
      lat++;
    end
    cmp("ack_latency", 64'(lat), 64'd5);
    cmp("first_active", 64'(slot_active), 64'b0001);
    cmp("first_x", 64'(slot_x[11:0]), 64'd320);
    cmp("first_y", 64'(slot_y[11:0]), 64'd452);
    cyc();
    cmp("ack_one_cycle", 64'(fire_ack), 64'd0);
    frame(1'b0, a);
    cmp("second_frame_y", 64'(slot_y[11:0]), 64'd448);

    // Reset in the middle of a sweep.
    fsync = 1'b1; cyc(); fsync = 1'b0; cyc(); cyc();
    rst_n = 1'b0; cyc(); cyc();
    cmp("midreset_busy", 64'(busy), 64'd0);
    cmp("midreset_active", 64'(slot_active), 64'd0);
    cmp("midreset_x", 64'(slot_x), 64'd0);
    cmp("midreset_y", 64'(slot_y), 64'd0);
    rst_n = 1'b1;
    frame(1'b0, a);
    cmp("post_reset_sweep_ack", 64'(a), 64'd0);
    cmp("post_reset_busy", 64'(busy), 64'd0);

    // Press every frame: cooldown spaces the shots nine frames apart until the pool is full.
    player_x = 12'd200;
    for (int f = 0; f < 37; f++) begin
      frame(1'b1, a);
      if (a) ack_frames.push_back(f);
    end
    cmp("ack_count", 64'(ack_frames.size()), 64'd4);
    for (int k = 0; k < ack_frames.size(); k++)
      cmp("ack_frame", 64'(ack_frames[k]), 64'(k * 9));
    cmp("pool_full", 64'(slot_active), 64'hf);

    // Hit while idle frees slot 2; the blocked press must not carry over.
    hit = 4'b0100; cyc(); hit = '0; cyc();
    frame(1'b0, a);
    cmp("no_carry_ack", 64'(a), 64'd0);
    cmp("hit_cleared", 64'(slot_active), 64'b1011);
    player_x = 12'd77;
    frame(1'b1, a);
    cmp("realloc_ack", 64'(a), 64'd1);
    cmp("realloc_active", 64'(slot_active), 64'hf);
    cmp("realloc_x", 64'(slot_x[35:24]), 64'd77);
    cmp("realloc_y", 64'(slot_y[35:24]), 64'd452);

    // Flight lifetime: 452 down to 4 takes 112 sweeps, the 113th removes it.
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1; cyc();
    player_x = 12'd5;
    frame(1'b1, a);
    n = 0;
    seen4 = 1'b0;
    while (slot_active[0] && n < 200) begin
      if (slot_y[11:0] == 12'd4) seen4 = 1'b1;
      frame(1'b0, a);
      n++;
    end
    cmp("sweeps_to_expire", 64'(n), 64'd113);
    cmp("saw_y4_active", 64'(seen4), 64'd1);

    // Random traffic, including fsync mid-sweep, hits in every phase and short resets.
    for (int c = 0; c < 3000; c++) begin
      fsync = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < N; b++) hit[b] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) fire = ~fire;
      player_x = 12'($urandom);
      rst_n = ($urandom_range(0, 799) != 0);
      cyc();
    end
    rst_n = 1'b1; fsync = 1'b0; hit = '0; fire = 1'b0;
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
